// File: rtl/seg_wb_queue_if.sv
// Bundle between decode/writeback (master) and the segment-write queue (slave).
// Handshake: an enqueue happens on a clock edge where enq_v && enq_rdy, and an alloc where alloc_v && alloc_ok; with the other level low, nothing happens.
interface seg_wb_queue_if #(
    parameter int DEPTH = 4,
    parameter int DW    = 16
) ();
    localparam int CW = $clog2(DEPTH + 1);

    logic          flush;
    logic          alloc_v;
    logic [2:0]    alloc_reg;
    logic          alloc_ok;
    logic          enq_v;
    logic [2:0]    enq_reg;
    logic [DW-1:0] enq_data;
    logic          enq_rdy;
    logic          hold;
    logic [2:0]    rd_v;
    logic [2:0]    rd_seg1;
    logic [2:0]    rd_seg2;
    logic [2:0]    rd_seg3;
    logic          seg_stall;
    logic          wr_en;
    logic [2:0]    wr_reg;
    logic [DW-1:0] wr_data;
    logic          cs_update;
    logic [CW-1:0] count;

    modport master (
        output flush, alloc_v, alloc_reg, enq_v, enq_reg, enq_data, hold,
               rd_v, rd_seg1, rd_seg2, rd_seg3,
        input  alloc_ok, enq_rdy, seg_stall, wr_en, wr_reg, wr_data, cs_update, count
    );

    modport slave (
        input  flush, alloc_v, alloc_reg, enq_v, enq_reg, enq_data, hold,
               rd_v, rd_seg1, rd_seg2, rd_seg3,
        output alloc_ok, enq_rdy, seg_stall, wr_en, wr_reg, wr_data, cs_update, count
    );
endinterface

// File: rtl/seg_wb_queue.sv
// Segment-register write queue: FIFO drained one entry per cycle into the regfile
// write port, plus per-register pending-write counters for decode stalls.
module seg_wb_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 16,
    parameter int CNT_W = 2
) (
    input logic           clk,
    input logic           rst,
    seg_wb_queue_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]    FULL    = CW'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [2:0]       q_reg  [DEPTH];
    logic [DW-1:0]    q_data [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    cnt;
    logic [CNT_W-1:0] pend [8];

    logic          wr_en_q;
    logic          cs_q;
    logic [2:0]    wr_reg_q;
    logic [DW-1:0] wr_data_q;

    logic       enq_rdy;
    logic       do_enq;
    logic       do_deq;
    logic       alloc_ok;
    logic       stall;
    logic [7:0] inc;
    logic [7:0] dec;
    logic       retire_bad;
    logic       enq_bad;

    assign enq_rdy = (cnt != FULL);
    assign do_enq  = bus.enq_v && enq_rdy;
    assign do_deq  = (cnt != '0) && !bus.hold;
    // A saturated register can still take an alloc while its retire lands this cycle.
    assign alloc_ok = (pend[bus.alloc_reg] != CNT_MAX) || (wr_en_q && (wr_reg_q == bus.alloc_reg));

    always_comb begin
        stall = 1'b0;
        if (bus.rd_v[0] && (pend[bus.rd_seg1] != '0)) stall = 1'b1;
        if (bus.rd_v[1] && (pend[bus.rd_seg2] != '0)) stall = 1'b1;
        if (bus.rd_v[2] && (pend[bus.rd_seg3] != '0)) stall = 1'b1;
    end

    always_comb begin
        inc = '0;
        dec = '0;
        for (int r = 0; r < 8; r++) begin
            inc[r] = bus.alloc_v && alloc_ok && (bus.alloc_reg == 3'(r));
            dec[r] = wr_en_q && (wr_reg_q == 3'(r));
        end
    end

    always_ff @(posedge clk) begin
        if (do_enq) begin
            q_reg[tail]  <= bus.enq_reg;
            q_data[tail] <= bus.enq_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            cnt       <= '0;
            wr_en_q   <= 1'b0;
            cs_q      <= 1'b0;
            wr_reg_q  <= '0;
            wr_data_q <= '0;
            for (int r = 0; r < 8; r++) pend[r] <= '0;
        end else if (bus.flush) begin
            head    <= '0;
            tail    <= '0;
            cnt     <= '0;
            wr_en_q <= 1'b0;
            cs_q    <= 1'b0;
            for (int r = 0; r < 8; r++) pend[r] <= '0;
        end else begin
            if (do_enq) tail <= tail + 1'b1;
            if (do_deq) begin
                head      <= head + 1'b1;
                wr_en_q   <= 1'b1;
                wr_reg_q  <= q_reg[head];
                wr_data_q <= q_data[head];
                cs_q      <= (q_reg[head] == 3'd1);
            end else begin
                wr_en_q <= 1'b0;
                cs_q    <= 1'b0;
            end
            if (do_enq && !do_deq)      cnt <= cnt + 1'b1;
            else if (!do_enq && do_deq) cnt <= cnt - 1'b1;
            // Counters decrement when the regfile captures the write, i.e. at the end of the wr_en cycle.
            for (int r = 0; r < 8; r++) begin
                if (inc[r] && !dec[r])                          pend[r] <= pend[r] + 1'b1;
                else if (dec[r] && !inc[r] && (pend[r] != '0))  pend[r] <= pend[r] - 1'b1;
            end
        end
    end

    assign retire_bad = wr_en_q && (pend[wr_reg_q] == '0);
    assign enq_bad    = do_enq && (pend[bus.enq_reg] == '0);

    a_no_retire_underflow: assert property (@(posedge clk) disable iff (rst || bus.flush) !retire_bad);
    a_enq_has_alloc:       assert property (@(posedge clk) disable iff (rst || bus.flush) !enq_bad);

    assign bus.alloc_ok  = alloc_ok;
    assign bus.enq_rdy   = enq_rdy;
    assign bus.seg_stall = stall;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_reg    = wr_reg_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.cs_update = cs_q;
    assign bus.count     = cnt;
endmodule

// File: tb/tb_seg_wb_queue.sv
// Bench for seg_wb_queue: directed vector table, hand sequences for reset mid-drain,
// then random traffic checked against a queue-based reference model.
module tb_seg_wb_queue;
    localparam int DEPTH   = 4;
    localparam int DW      = 16;
    localparam int CNT_MAX = 3;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg_wb_queue_if #(.DEPTH(DEPTH), .DW(DW)) bus ();
    seg_wb_queue #(.DEPTH(DEPTH), .DW(DW), .CNT_W(2)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int fl, av, ar, ev, er, ed, h, rv, s1, s2, s3;
        int x_we, x_cs, x_wr, x_wd, x_cnt, x_rdy, x_ok, x_st;
    } vec_t;
    vec_t tbl[$];

    // reference model: queued entries as {reg, data}, outstanding writes per register
    logic [18:0] exp_q[$];
    int          pend_m[8];
    int          owed[8];
    logic        m_wr_en;
    logic        m_cs;
    logic [2:0]  m_wr_reg;
    logic [15:0] m_wr_data;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t v(input int fl, av, ar, ev, er, ed, h, rv, s1, s2, s3,
                               input int we, cs, wr, wd, cnt, rdy, ok, st);
        vec_t r;
        r.fl = fl; r.av = av; r.ar = ar; r.ev = ev; r.er = er; r.ed = ed; r.h = h;
        r.rv = rv; r.s1 = s1; r.s2 = s2; r.s3 = s3;
        r.x_we = we; r.x_cs = cs; r.x_wr = wr; r.x_wd = wd;
        r.x_cnt = cnt; r.x_rdy = rdy; r.x_ok = ok; r.x_st = st;
        return r;
    endfunction

    // driver
    task automatic drive(input int fl, av, ar, ev, er, ed, h, rv, s1, s2, s3);
        bus.flush     = fl[0];
        bus.alloc_v   = av[0];
        bus.alloc_reg = 3'(ar);
        bus.enq_v     = ev[0];
        bus.enq_reg   = 3'(er);
        bus.enq_data  = 16'(ed);
        bus.hold      = h[0];
        bus.rd_v      = 3'(rv);
        bus.rd_seg1   = 3'(s1);
        bus.rd_seg2   = 3'(s2);
        bus.rd_seg3   = 3'(s3);
    endtask

    function automatic bit model_alloc_ok(input logic [2:0] r);
        return (pend_m[r] < CNT_MAX) || (m_wr_en && (m_wr_reg == r));
    endfunction

    function automatic bit model_stall();
        return (bus.rd_v[0] && pend_m[bus.rd_seg1] > 0) ||
               (bus.rd_v[1] && pend_m[bus.rd_seg2] > 0) ||
               (bus.rd_v[2] && pend_m[bus.rd_seg3] > 0);
    endfunction

    task automatic check_model();
        check("m_wr_en",     bus.wr_en,     m_wr_en);
        check("m_cs_update", bus.cs_update, m_cs);
        check("m_wr_reg",    bus.wr_reg,    m_wr_reg);
        check("m_wr_data",   bus.wr_data,   m_wr_data);
        check("m_count",     bus.count,     exp_q.size());
        check("m_enq_rdy",   bus.enq_rdy,   exp_q.size() < DEPTH);
        check("m_alloc_ok",  bus.alloc_ok,  model_alloc_ok(bus.alloc_reg));
        check("m_seg_stall", bus.seg_stall, model_stall());
    endtask

    // advance the model across one clock edge using the inputs held over it
    task automatic model_edge();
        bit          do_enq;
        bit          do_deq;
        logic [18:0] e;
        if (rst || bus.flush) begin
            exp_q.delete();
            for (int r = 0; r < 8; r++) begin
                pend_m[r] = 0;
                owed[r]   = 0;
            end
            m_wr_en = 1'b0;
            m_cs    = 1'b0;
            if (rst) begin
                m_wr_reg  = '0;
                m_wr_data = '0;
            end
            return;
        end
        if (bus.alloc_v && model_alloc_ok(bus.alloc_reg)) begin
            pend_m[bus.alloc_reg]++;
            owed[bus.alloc_reg]++;
        end
        if (m_wr_en && pend_m[m_wr_reg] > 0) pend_m[m_wr_reg]--;
        do_enq = bus.enq_v && (exp_q.size() < DEPTH);
        do_deq = (exp_q.size() > 0) && !bus.hold;
        if (do_deq) begin
            e         = exp_q.pop_front();
            m_wr_en   = 1'b1;
            m_wr_reg  = e[18:16];
            m_wr_data = e[15:0];
            m_cs      = (e[18:16] == 3'd1);
        end else begin
            m_wr_en = 1'b0;
            m_cs    = 1'b0;
        end
        if (do_enq) begin
            exp_q.push_back({bus.enq_reg, bus.enq_data});
            owed[bus.enq_reg]--;
        end
    endtask

    task automatic at_negedge(input bit chk);
        @(negedge clk);
        if (chk) check_model();
    endtask

    task automatic at_posedge();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic run_row(input int i);
        vec_t t;
        t = tbl[i];
        drive(t.fl, t.av, t.ar, t.ev, t.er, t.ed, t.h, t.rv, t.s1, t.s2, t.s3);
        at_negedge(1'b1);
        check($sformatf("t%0d wr_en", i),     bus.wr_en,     t.x_we);
        check($sformatf("t%0d cs_update", i), bus.cs_update, t.x_cs);
        check($sformatf("t%0d wr_reg", i),    bus.wr_reg,    t.x_wr);
        check($sformatf("t%0d wr_data", i),   bus.wr_data,   t.x_wd);
        check($sformatf("t%0d count", i),     bus.count,     t.x_cnt);
        check($sformatf("t%0d enq_rdy", i),   bus.enq_rdy,   t.x_rdy);
        check($sformatf("t%0d alloc_ok", i),  bus.alloc_ok,  t.x_ok);
        check($sformatf("t%0d seg_stall", i), bus.seg_stall, t.x_st);
        at_posedge();
    endtask

    initial begin
        int cand[$];
        int er;
        int ev;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk);
            model_edge();
        end
        #1;
        rst = 1'b0;

        // reset state
        drive(0, 0, 5, 0, 0, 0, 0, 7, 0, 3, 7);
        at_negedge(1'b1);
        check("rst wr_en",     bus.wr_en,     0);
        check("rst cs_update", bus.cs_update, 0);
        check("rst wr_reg",    bus.wr_reg,    0);
        check("rst wr_data",   bus.wr_data,   0);
        check("rst count",     bus.count,     0);
        check("rst enq_rdy",   bus.enq_rdy,   1);
        check("rst alloc_ok",  bus.alloc_ok,  1);
        check("rst seg_stall", bus.seg_stall, 0);
        at_posedge();

        // single write to ES, read port 1 watching ES
        tbl.push_back(v(0,1,0, 0,0,0,       0, 1,0,0,0, 0,0,0,0,       0,1,1,0));
        tbl.push_back(v(0,0,0, 1,0,'h1234,  0, 1,0,0,0, 0,0,0,0,       0,1,1,1));
        tbl.push_back(v(0,0,0, 0,0,0,       0, 1,0,0,0, 0,0,0,0,       1,1,1,1));
        tbl.push_back(v(0,0,0, 0,0,0,       0, 1,0,0,0, 1,0,0,'h1234,  0,1,1,1));
        tbl.push_back(v(0,0,0, 0,0,0,       0, 1,0,0,0, 0,0,0,'h1234,  0,1,1,0));
        // fill to DEPTH under hold, fifth enqueue ignored, then drain in order
        for (int r = 2; r <= 5; r++)
            tbl.push_back(v(0,1,r, 0,0,0, 1, 0,0,0,0, 0,0,0,'h1234, 0,1,1,0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(v(0,0,0, 1,2+i,'hA000+i, 1, 0,0,0,0, 0,0,0,'h1234, i,1,1,0));
        tbl.push_back(v(0,0,0, 1,6,'hBEEF,  1, 0,0,0,0, 0,0,0,'h1234,  4,0,1,0));
        tbl.push_back(v(0,0,0, 0,0,0,       0, 0,0,0,0, 0,0,0,'h1234,  4,0,1,0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(v(0,0,0, 0,0,0, 0, 0,0,0,0, 1,0,2+i,'hA000+i, 3-i,1,1,0));
        tbl.push_back(v(0,0,0, 0,0,0,       0, 0,0,0,0, 0,0,5,'hA003,  0,1,1,0));
        // CS write followed by a DS-index-2 write; read port 3 watches CS
        tbl.push_back(v(0,1,1, 0,0,0,       0, 4,0,0,1, 0,0,5,'hA003,  0,1,1,0));
        tbl.push_back(v(0,1,2, 0,0,0,       0, 4,0,0,1, 0,0,5,'hA003,  0,1,1,1));
        tbl.push_back(v(0,0,0, 1,1,'hF000,  0, 4,0,0,1, 0,0,5,'hA003,  0,1,1,1));
        tbl.push_back(v(0,0,0, 1,2,'h0222,  0, 4,0,0,1, 0,0,5,'hA003,  1,1,1,1));
        tbl.push_back(v(0,0,0, 0,0,0,       0, 4,0,0,1, 1,1,1,'hF000,  1,1,1,1));
        tbl.push_back(v(0,0,0, 0,0,0,       0, 4,0,0,1, 1,0,2,'h0222,  0,1,1,0));
        tbl.push_back(v(0,0,0, 0,0,0,       0, 4,0,0,1, 0,0,2,'h0222,  0,1,1,0));
        // DS saturation and alloc during a DS retire; read port 2 watches DS
        tbl.push_back(v(0,1,3, 0,0,0,       0, 2,0,3,0, 0,0,2,'h0222,  0,1,1,0));
        tbl.push_back(v(0,1,3, 0,0,0,       0, 2,0,3,0, 0,0,2,'h0222,  0,1,1,1));
        tbl.push_back(v(0,1,3, 0,0,0,       0, 2,0,3,0, 0,0,2,'h0222,  0,1,1,1));
        tbl.push_back(v(0,1,3, 0,0,0,       0, 2,0,3,0, 0,0,2,'h0222,  0,1,0,1));
        tbl.push_back(v(0,0,4, 0,0,0,       0, 2,0,3,0, 0,0,2,'h0222,  0,1,1,1));
        tbl.push_back(v(0,0,0, 1,3,'hD001,  0, 2,0,3,0, 0,0,2,'h0222,  0,1,1,1));
        tbl.push_back(v(0,0,0, 0,0,0,       0, 2,0,3,0, 0,0,2,'h0222,  1,1,1,1));
        tbl.push_back(v(0,1,3, 0,0,0,       0, 2,0,3,0, 1,0,3,'hD001,  0,1,1,1));
        tbl.push_back(v(0,0,3, 0,0,0,       0, 2,0,3,0, 0,0,3,'hD001,  0,1,0,1));
        // three queued, one drained, flush with a same-cycle enqueue
        for (int i = 0; i < 3; i++)
            tbl.push_back(v(0,0,0, 1,3,'hE000+i, 1, 7,3,1,4, 0,0,3,'hD001, i,1,1,1));
        tbl.push_back(v(0,0,0, 0,0,0,       0, 7,3,1,4, 0,0,3,'hD001,  3,1,1,1));
        tbl.push_back(v(1,0,0, 1,3,'hE003,  0, 7,3,1,4, 1,0,3,'hE000,  2,1,1,1));
        tbl.push_back(v(0,0,0, 0,0,0,       0, 7,3,1,4, 0,0,3,'hE000,  0,1,1,0));
        tbl.push_back(v(0,0,0, 0,0,0,       0, 7,3,1,4, 0,0,3,'hE000,  0,1,1,0));
        for (int i = 0; i < tbl.size(); i++) run_row(i);

        // reset in the middle of a drain
        drive(0, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0);       at_negedge(1'b1); at_posedge();
        drive(0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0);       at_negedge(1'b1); at_posedge();
        drive(0, 0, 0, 1, 6, 'h6666, 0, 0, 0, 0, 0);  at_negedge(1'b1); at_posedge();
        drive(0, 0, 0, 1, 7, 'h7777, 0, 0, 0, 0, 0);  at_negedge(1'b1); at_posedge();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        at_negedge(1'b1);
        check("mid wr_en",   bus.wr_en,   1);
        check("mid wr_data", bus.wr_data, 'h6666);
        at_posedge();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 7, 6, 7, 0);
        at_negedge(1'b1);
        check("post_rst wr_en",     bus.wr_en,     0);
        check("post_rst count",     bus.count,     0);
        check("post_rst wr_data",   bus.wr_data,   0);
        check("post_rst seg_stall", bus.seg_stall, 0);
        at_posedge();
        at_negedge(1'b1);
        check("post_rst2 wr_en", bus.wr_en, 0);
        at_posedge();

        // random traffic; enqueues only target registers with an accepted, not yet enqueued alloc
        for (int c = 0; c < 1500; c++) begin
            cand.delete();
            for (int r = 0; r < 8; r++) if (owed[r] > 0) cand.push_back(r);
            ev = 0;
            er = 0;
            if (cand.size() > 0 && $urandom_range(0, 2) != 0) begin
                ev = 1;
                er = cand[$urandom_range(0, cand.size() - 1)];
            end
            drive(($urandom_range(0, 59) == 0) ? 1 : 0, $urandom_range(0, 1), $urandom_range(0, 7),
                  ev, er, $urandom_range(0, 65535), ($urandom_range(0, 3) == 0) ? 1 : 0,
                  $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            rst = ($urandom_range(0, 149) == 0);
            at_negedge(1'b1);
            at_posedge();
            rst = 1'b0;
        end

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/seg_wb_queue.md
Name: seg_wb_queue

Overview:
- Writeback-side front end for the 8-entry segment register file.
- Buffers segment-register writes (MOV Sreg, POP Sreg, far JMP/CALL/RET CS loads) in a small FIFO and drains them one per cycle into the file's single write port (wr_en/wr_reg/wr_data).
- Keeps a per-register pending-write scoreboard so decode can stall readers of a segment register that has an outstanding write.
- Flags CS updates for front-end redirect.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..8.
- DW, 16, segment data width.
- CNT_W, 2, width of each per-register pending counter; saturates at 2^CNT_W-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock, synchronous, active-high.
- flush  in  1  pipeline flush; discards all queued and pending writes.
- alloc_v  in  1  decode issues an instruction that will write a segment register.
- alloc_reg  in  3  segment register targeted by alloc_v.
- alloc_ok  out  1  alloc may be accepted this cycle (combinational).
- enq_v  in  1  writeback presents a segment write.
- enq_reg  in  3  target segment register.
- enq_data  in  DW  value to write.
- enq_rdy  out  1  FIFO can accept; equals count < DEPTH.
- hold  in  1  suppresses dequeue this cycle.
- rd_v  in  3  per-port read-valid for decode's three segment read ports.
- rd_seg1, rd_seg2, rd_seg3  in  3 each  segment selects of read ports 1..3.
- seg_stall  out  1  a valid read hits a register with pending write (combinational).
- wr_en  out  1  registered write enable to segment regfile.
- wr_reg  out  3  registered write index.
- wr_data  out  DW  registered write data.
- cs_update  out  1  registered; high in the same cycle as wr_en when wr_reg==1 (CS).
- count  out  clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset (rst high at posedge):
  - FIFO pointers and count = 0.
  - All 8 pending counters = 0.
  - wr_en = 0, wr_reg = 0, wr_data = 0, cs_update = 0.
  - Any in-flight content is lost; reset mid-drain produces no further wr_en.
- flush: same clearing as reset, except wr_reg and wr_data hold their values.
  - Takes priority over enq, alloc and dequeue in the same cycle.
  - rst has priority over flush.
- Enqueue: at posedge, if enq_v && enq_rdy, write {enq_reg, enq_data} at tail and advance tail (wraps modulo DEPTH).
  - enq_v with enq_rdy=0 is ignored; no overwrite.
  - enq_rdy does not account for a same-cycle dequeue (conservative full).
- Dequeue: at posedge, if count>0 && !hold:
  - wr_en <= 1; wr_reg/wr_data <= head; cs_update <= (head reg == 1).
  - Head advances, wrapping modulo DEPTH.
  - Otherwise wr_en <= 0 and cs_update <= 0; wr_reg/wr_data hold.
- Latency: an enqueue accepted at edge E into an empty FIFO with hold low gives wr_en high in the cycle after edge E+1.
  - Sustained throughput is 1 write/cycle.
- Simultaneous enqueue and dequeue: count unchanged; legal at full and at empty only as governed by the rules above.
- Scoreboard, pending counter per register:
  - +1 on alloc_v && alloc_ok for alloc_reg.
  - −1 in the cycle wr_en=1 for wr_reg, applied at that cycle's closing edge, i.e. when the regfile captures the data.
  - Same-cycle alloc and retire of the same register leave the counter unchanged.
  - The counter never wraps. Decrement at 0 is held at 0 and counts as a protocol error, flagged by an assertion.
- alloc_ok = counter[alloc_reg] != max, OR the same register is retiring this cycle.
  - alloc_v with alloc_ok=0 has no effect; the issuer must hold the instruction.
- seg_stall = OR over k of (rd_v[k] && counter[rd_seg_k] != 0).
  - Stall remains high during the wr_en cycle, because the regfile still returns the old value.
  - Stall clears the cycle after.
- Every enqueued write must have a prior accepted alloc; enq without alloc is an assertion error.

Test Plan:
- Reset → after rst high 1 cycle:
  - wr_en=0, count=0, enq_rdy=1, seg_stall=0 for any rd_v.
  - alloc_ok=1.
- Single write:
  - Stimulus: alloc ES (0); next cycle enq reg0 data 16'h1234; rd_v=3'b001, rd_seg1=0 held throughout.
  - Required response: seg_stall=1 from the cycle after alloc through the wr_en cycle; wr_en=1, wr_reg=0, wr_data=16'h1234 two cycles after enq; seg_stall=0 the next cycle.
- Full/backpressure with DEPTH=4:
  - Stimulus: hold=1; enqueue 4 writes (regs 2,3,4,5, data 16'hA000+i).
  - Required response: count=4, enq_rdy=0; 5th enq ignored.
  - Stimulus: release hold.
  - Required response: 4 consecutive wr_en cycles in order with data A000..A003; count returns to 0.
- CS update:
  - Stimulus: enq reg1 data 16'hF000.
  - Required response: wr_en and cs_update both high in the same cycle, one cycle wide; cs_update low for a reg2 write.
- Counter saturation and same-cycle retire (CNT_W=2):
  - Stimulus: 3 allocs to DS (3).
  - Required response: alloc_ok=0 for DS, alloc_ok=1 for FS.
  - Stimulus: alloc DS in the wr_en cycle of a DS write.
  - Required response: accepted; counter stays 3.
- Flush mid-drain:
  - Stimulus: 3 queued entries, 1 drained; assert flush together with enq_v.
  - Required response: next cycle count=0, wr_en=0, all counters 0, seg_stall=0; the flush-cycle enq is discarded.
